dp_microseq: RTL and testbench

- Synthesizable, parametrised control sequencer for the datapath. It replaces hand-timed bench stimulus with a clocked FSM.
- Phase 1 preloads up to NUM_PRELOAD general registers through the MDR (Reg_load a/b pairs).
- Phase 2 runs one fetch/execute sequence (T0..T5) for a supplied instruction word.
- It drives the datapath's enable vector, bus-select code, MR_Read, MDataIn and Control_Signals, one state per clock. Behaviour is generalised over data width, preload depth and unary/binary ALU ops.

---
 rtl/dp_microseq.sv | 206 ++++++++++++++++++++
 tb/tb_dp_microseq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_microseq.sv
// Datapath control sequencer: preloads registers through the MDR, then runs one
// fetch/execute pass (T0..T5) for a latched instruction word. All outputs registered.
module dp_microseq #(
    parameter int         DATA_W      = 32,
    parameter int         NUM_PRELOAD = 3,
    parameter int         EN_W        = 32,
    parameter int         SEL_W       = 5,
    parameter int         MDR_IDX     = 21,
    parameter int         PC_IDX      = 20,
    parameter int         IR_IDX      = 23,
    parameter int         Y_IDX       = 22,
    parameter int         Z_IDX       = 24,
    parameter int         MAR_IDX     = 25,
    parameter logic [4:0] UNARY_OP0   = 5'd18,
    parameter logic [4:0] UNARY_OP1   = 5'd17,
    localparam int        IDX_W       = (NUM_PRELOAD > 1) ? $clog2(NUM_PRELOAD) : 1,
    localparam int        CNT_W       = $clog2(NUM_PRELOAD) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_we,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [3:0]        ld_reg,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CNT_W-1:0]  ld_cnt,
    input  logic [DATA_W-1:0] instr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [EN_W-1:0]   enable,
    output logic [SEL_W-1:0]  busSelect,
    output logic              MR_Read,
    output logic [DATA_W-1:0] MDataIn,
    output logic [3:0]        Control_Signals,
    output logic              pc_inc
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_DONE
    } state_t;

    localparam int                TBL_N = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  NP_C  = CNT_W'(NUM_PRELOAD);
    localparam logic [IDX_W:0]    NP_I  = (IDX_W + 1)'(NUM_PRELOAD);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d, cnt_q, cnt_d, cnt_clamp;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [3:0]          tbl_reg_q  [TBL_N];
    logic [DATA_W-1:0]   tbl_data_q [TBL_N];
    logic                tbl_wr;

    logic [4:0]          opcode;
    logic [3:0]          ra, rb, rc;
    logic                unary;

    logic [EN_W-1:0]     en_q, en_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                mrd_q, mrd_d, pcinc_q, pcinc_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_W-1:0]   mdin_q, mdin_d;
    logic [3:0]          ctl_q, ctl_d;

    // Decode from the next-cycle instruction so the start edge already sees it.
    assign opcode = instr_d[31:27];
    assign ra     = instr_d[26:23];
    assign rb     = instr_d[22:19];
    assign rc     = instr_d[18:15];
    assign unary  = (opcode == UNARY_OP0) || (opcode == UNARY_OP1);

    assign cnt_clamp = (ld_cnt > NP_C) ? NP_C : ld_cnt;
    assign tbl_wr    = (state_q == S_IDLE) && ld_we && ({1'b0, ld_idx} < NP_I);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    instr_d = instr;
                    cnt_d   = cnt_clamp;
                    idx_d   = '0;
                    state_d = (cnt_clamp != '0) ? S_LOAD_A : S_T0;
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                if ((idx_q + CNT_W'(1)) < cnt_q) begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_LOAD_A;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = unary ? S_T4 : S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        en_d    = '0;
        sel_d   = '0;
        mrd_d   = 1'b0;
        mdin_d  = '0;
        ctl_d   = '0;
        pcinc_d = 1'b0;
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        case (state_d)
            S_LOAD_A: begin
                mdin_d         = tbl_data_q[idx_d[IDX_W-1:0]];
                mrd_d          = 1'b1;
                en_d[MDR_IDX]  = 1'b1;
            end
            S_LOAD_B: begin
                sel_d = SEL_W'(MDR_IDX);
                en_d  = EN_W'(1) << tbl_reg_q[idx_d[IDX_W-1:0]];
            end
            S_T0: begin
                sel_d          = SEL_W'(PC_IDX);
                en_d[MAR_IDX]  = 1'b1;
                en_d[PC_IDX]   = 1'b1;
                pcinc_d        = 1'b1;
            end
            S_T1: begin
                mdin_d         = instr_d;
                mrd_d          = 1'b1;
                en_d[MDR_IDX]  = 1'b1;
            end
            S_T2: begin
                sel_d          = SEL_W'(MDR_IDX);
                en_d[IR_IDX]   = 1'b1;
            end
            S_T3: begin
                sel_d          = SEL_W'(rb);
                en_d[Y_IDX]    = 1'b1;
            end
            S_T4: begin
                sel_d          = unary ? SEL_W'(rb) : SEL_W'(rc);
                ctl_d          = opcode[3:0];
                en_d[Z_IDX]    = 1'b1;
            end
            S_T5: begin
                sel_d = SEL_W'(Z_IDX);
                en_d  = EN_W'(1) << ra;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            en_q    <= '0;
            sel_q   <= '0;
            mrd_q   <= 1'b0;
            mdin_q  <= '0;
            ctl_q   <= '0;
            pcinc_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < TBL_N; i++) begin
                tbl_reg_q[i]  <= '0;
                tbl_data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            mrd_q   <= mrd_d;
            mdin_q  <= mdin_d;
            ctl_q   <= ctl_d;
            pcinc_q <= pcinc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (tbl_wr) begin
                tbl_reg_q[ld_idx]  <= ld_reg;
                tbl_data_q[ld_idx] <= ld_data;
            end
        end
    end

    assign enable          = en_q;
    assign busSelect       = sel_q;
    assign MR_Read         = mrd_q;
    assign MDataIn         = mdin_q;
    assign Control_Signals = ctl_q;
    assign pc_inc          = pcinc_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_dp_microseq.sv
// Scoreboard bench for dp_microseq: each sequence pushes its expected per-cycle
// output words, which are popped and compared on the falling edge.
module tb_dp_microseq;

    logic        clk = 1'b0;
    logic        clr;
    logic        ld_we;
    logic [1:0]  ld_idx;
    logic [3:0]  ld_reg;
    logic [31:0] ld_data;
    logic [2:0]  ld_cnt;
    logic [31:0] instr;
    logic        start;
    logic        busy, done, MR_Read, pc_inc;
    logic [31:0] enable, MDataIn;
    logic [4:0]  busSelect;
    logic [3:0]  Control_Signals;

    always #5 clk = ~clk;

    dp_microseq dut (
        .clk(clk), .clr(clr), .ld_we(ld_we), .ld_idx(ld_idx), .ld_reg(ld_reg),
        .ld_data(ld_data), .ld_cnt(ld_cnt), .instr(instr), .start(start),
        .busy(busy), .done(done), .enable(enable), .busSelect(busSelect),
        .MR_Read(MR_Read), .MDataIn(MDataIn), .Control_Signals(Control_Signals),
        .pc_inc(pc_inc)
    );

    typedef struct packed {
        logic [31:0] en;
        logic [4:0]  sel;
        logic        mrd;
        logic [31:0] mdin;
        logic [3:0]  ctl;
        logic        pcinc;
        logic        busy;
        logic        done;
    } out_t;

    out_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  m_reg  [3];
    logic [31:0] m_data [3];

    localparam logic [31:0] I_NOT = 32'h90900000;  // NOT: Ra=1, Rb=2
    localparam logic [31:0] I_BIN = 32'h51908000;  // op 10: Ra=3, Rb=2, Rc=1

    function automatic out_t sample_out();
        out_t o;
        o = {enable, busSelect, MR_Read, MDataIn, Control_Signals, pc_inc, busy, done};
        return o;
    endfunction

    task automatic push_seq(input int cnt, input logic [31:0] ins);
        out_t e;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        bit un;
        op = ins[31:27]; ra = ins[26:23]; rb = ins[22:19]; rc = ins[18:15];
        un = (op == 5'd18) || (op == 5'd17);
        for (int i = 0; i < cnt; i++) begin
            e = '0; e.busy = 1'b1; e.en = 32'h1 << 21; e.mrd = 1'b1; e.mdin = m_data[i];
            sb.push_back(e);
            e = '0; e.busy = 1'b1; e.sel = 5'd21; e.en = 32'h1 << m_reg[i];
            sb.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.sel = 5'd20; e.en = (32'h1 << 25) | (32'h1 << 20); e.pcinc = 1'b1;
        sb.push_back(e);
        e = '0; e.busy = 1'b1; e.mdin = ins; e.mrd = 1'b1; e.en = 32'h1 << 21;
        sb.push_back(e);
        e = '0; e.busy = 1'b1; e.sel = 5'd21; e.en = 32'h1 << 23;
        sb.push_back(e);
        if (!un) begin
            e = '0; e.busy = 1'b1; e.sel = {1'b0, rb}; e.en = 32'h1 << 22;
            sb.push_back(e);
        end
        e = '0; e.busy = 1'b1; e.sel = {1'b0, (un ? rb : rc)}; e.ctl = op[3:0]; e.en = 32'h1 << 24;
        sb.push_back(e);
        e = '0; e.busy = 1'b1; e.sel = 5'd24; e.en = 32'h1 << ra;
        sb.push_back(e);
        e = '0; e.done = 1'b1;
        sb.push_back(e);
        e = '0;
        sb.push_back(e);
    endtask

    task automatic load_entry(input int idx, input logic [3:0] r, input logic [31:0] d);
        ld_idx = 2'(idx); ld_reg = r; ld_data = d; ld_we = 1'b1;
        @(posedge clk); #2;
        ld_we = 1'b0;
        if (idx < 3) begin
            m_reg[idx] = r; m_data[idx] = d;
        end
        @(negedge clk);
    endtask

    // Cycle k is the state entered on the k-th rising edge after start is sampled.
    task automatic run_seq(input int cnt, input logic [31:0] ins, input int poke_start,
                           input int poke_we, input int abort_at,
                           output int done_cyc, output int n_done);
        out_t e, obs;
        int k;
        done_cyc = -1; n_done = 0; k = 0;
        push_seq(cnt, ins);
        ld_cnt = 3'(cnt); instr = ins; start = 1'b1;
        while (sb.size() > 0 && k < 100) begin
            @(posedge clk); #2;
            k++;
            start   = (k == poke_start);
            ld_we   = (k == poke_we);
            ld_idx  = 2'd0; ld_reg = 4'hF; ld_data = 32'hBAD0BAD0;
            if (k == abort_at) begin
                clr = 1'b1;
                #1;
                obs = sample_out();
                checks++;
                if (obs !== out_t'(0)) begin
                    failures++;
                    $display("FAIL abort_zero got=%h want=0", obs);
                end
                sb.delete();
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        failures++;
                        $display("FAIL abort_hold done=%b busy=%b want 0/0", done, busy);
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    m_reg[i] = '0; m_data[i] = '0;
                end
                clr = 1'b0;
            end else begin
                @(negedge clk);
                e = sb.pop_front();
                obs = sample_out();
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL seq_out cyc=%0d got=%h want=%h", k, obs, e);
                end
                if (done === 1'b1) begin
                    n_done++;
                    if (done_cyc < 0) done_cyc = k;
                end
            end
        end
        start = 1'b0; ld_we = 1'b0;
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL seq_timeout left=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        out_t obs;
        repeat (2) @(negedge clk);
        obs = sample_out();
        checks++;
        if (obs !== out_t'(0)) begin
            failures++;
            $display("FAIL reset_out got=%h want=0", obs);
        end
        clr = 1'b0;
        @(negedge clk);
        obs = sample_out();
        checks++;
        if (obs !== out_t'(0)) begin
            failures++;
            $display("FAIL idle_out got=%h want=0", obs);
        end
    endtask

    task automatic test_unary_preload();
        int dc, nd;
        load_entry(0, 4'd2, 32'h12);
        load_entry(1, 4'd3, 32'h14);
        load_entry(2, 4'd1, 32'h18);
        run_seq(3, I_NOT, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 12) begin failures++; $display("FAIL unary_latency got=%0d want=12", dc); end
        checks++;
        if (nd !== 1) begin failures++; $display("FAIL unary_done_cnt got=%0d want=1", nd); end
    endtask

    task automatic test_binary_preload();
        int dc, nd;
        run_seq(3, I_BIN, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 13) begin failures++; $display("FAIL binary_latency got=%0d want=13", dc); end
    endtask

    task automatic test_no_preload();
        int dc, nd;
        run_seq(0, I_BIN, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 7) begin failures++; $display("FAIL nopre_latency got=%0d want=7", dc); end
    endtask

    task automatic test_ignored_inputs();
        int dc, nd;
        run_seq(3, I_NOT, 9, 1, -1, dc, nd);
        checks++;
        if (dc !== 12) begin failures++; $display("FAIL ignore_latency got=%0d want=12", dc); end
        checks++;
        if (nd !== 1) begin failures++; $display("FAIL ignore_done_cnt got=%0d want=1", nd); end
        repeat (2) @(negedge clk);
        run_seq(3, I_BIN, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 13) begin failures++; $display("FAIL ignore_rerun got=%0d want=13", dc); end
    endtask

    task automatic test_clr_abort();
        int dc, nd;
        run_seq(3, I_NOT, -1, -1, 4, dc, nd);
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL abort_done_cnt got=%0d want=0", nd); end
        run_seq(0, I_BIN, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 7) begin failures++; $display("FAIL post_abort_latency got=%0d want=7", dc); end
        run_seq(1, I_BIN, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 9) begin failures++; $display("FAIL cleared_tbl_latency got=%0d want=9", dc); end
    endtask

    task automatic test_bad_idx();
        int dc, nd;
        load_entry(0, 4'd5, 32'hA1);
        load_entry(1, 4'd6, 32'hB2);
        load_entry(3, 4'd9, 32'hDEAD);
        load_entry(2, 4'd7, 32'hC3);
        run_seq(3, I_NOT, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 12) begin failures++; $display("FAIL badidx_latency got=%0d want=12", dc); end
    endtask

    task automatic test_back_to_back();
        int dc, nd;
        logic [31:0] i_neg, i_b2;
        i_neg = {5'd17, 4'd4, 4'd5, 4'd6, 15'd0};
        i_b2  = {5'd3, 4'd7, 4'd8, 4'd9, 15'd0};
        run_seq(1, i_neg, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 8) begin failures++; $display("FAIL b2b_first got=%0d want=8", dc); end
        run_seq(2, i_b2, -1, -1, -1, dc, nd);
        checks++;
        if (dc !== 11) begin failures++; $display("FAIL b2b_second got=%0d want=11", dc); end
    endtask

    initial begin
        clr = 1'b1; ld_we = 1'b0; ld_idx = '0; ld_reg = '0; ld_data = '0;
        ld_cnt = '0; instr = '0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_reg[i] = '0; m_data[i] = '0;
        end
        test_reset();
        test_unary_preload();
        test_binary_preload();
        test_no_preload();
        test_ignored_inputs();
        test_clr_abort();
        test_bad_idx();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
